// File: rtl/game_move_arbiter_if.sv
// Move-arbiter bundle: the two requester handshakes, the one-hot move pulses
// towards the game FSM, the game's end flags and the status outputs.
//   slave  : the arbiter side (takes requests/flags, drives readies, pulses, status)
//   master : the environment side (requesters, game model, observers)
interface game_move_arbiter_if #(
    parameter int unsigned COUNT_W = 8
);
    logic               p0_valid;
    logic [1:0]         p0_dir;
    logic               p0_ready;
    logic               p1_valid;
    logic [1:0]         p1_dir;
    logic               p1_ready;
    logic               n;
    logic               s;
    logic               e;
    logic               w;
    logic               game_d;
    logic               game_win;
    logic               game_over;
    logic [1:0]         result;
    logic [COUNT_W-1:0] move_count;
    logic               last_player;

    modport slave (
        input  p0_valid, p0_dir, p1_valid, p1_dir, game_d, game_win,
        output p0_ready, p1_ready, n, s, e, w,
               game_over, result, move_count, last_player
    );

    modport master (
        output p0_valid, p0_dir, p1_valid, p1_dir, game_d, game_win,
        input  p0_ready, p1_ready, n, s, e, w,
               game_over, result, move_count, last_player
    );
endinterface

// File: rtl/game_move_arbiter.sv
// Round-robin arbiter that feeds two players' moves into the game FSM as
// one-cycle one-hot n/s/e/w pulses, spaced by a settle window, and freezes
// once the game reports dead/win or the move budget is used up.
// Ports:
//   clock : system clock, all state on posedge
//   R     : synchronous active-high reset
//   bus   : game_move_arbiter_if.slave (handshakes, move pulses, end flags, status)
module game_move_arbiter #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned MAX_MOVES  = 64,
    parameter int unsigned COUNT_W    = 8
) (
    input  logic               clock,
    input  logic               R,
    game_move_arbiter_if.slave bus
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYC + 1);

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_WIN     = 2'b01;
    localparam logic [1:0] RES_DEAD    = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                rr_q, rr_d;            // 0: p0 favoured, 1: p1 favoured
    logic [3:0]          pulse_q, pulse_d;      // bit index = direction code
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [COUNT_W-1:0]  move_count_q, move_count_d;
    logic                last_q, last_d;
    logic [1:0]          result_q, result_d;
    logic                over_q, over_d;

    logic       end_flag_c;
    logic [1:0] end_res_c;
    logic       arb_ok_c;
    logic       grant0_c;
    logic       grant1_c;

    // Dead outranks win when both are raised together.
    assign end_flag_c = bus.game_d | bus.game_win;
    assign end_res_c  = bus.game_d ? RES_DEAD : RES_WIN;

    // Grants only in IDLE, never during reset, and withheld when the game is ending.
    assign arb_ok_c = (state_q == S_IDLE) && !R && !end_flag_c;
    assign grant0_c = arb_ok_c && bus.p0_valid && (!bus.p1_valid || !rr_q);
    assign grant1_c = arb_ok_c && bus.p1_valid && (!bus.p0_valid || rr_q);

    // State register.
    always_ff @(posedge clock) begin
        if (R) begin
            state_q      <= S_IDLE;
            rr_q         <= 1'b0;
            pulse_q      <= '0;
            settle_q     <= '0;
            move_count_q <= '0;
            last_q       <= 1'b0;
            result_q     <= RES_NONE;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            pulse_q      <= pulse_d;
            settle_q     <= settle_d;
            move_count_q <= move_count_d;
            last_q       <= last_d;
            result_q     <= result_d;
            over_q       <= over_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        pulse_d      = '0;
        settle_d     = settle_q;
        move_count_d = move_count_q;
        last_d       = last_q;
        result_d     = result_q;
        over_d       = over_q;

        unique case (state_q)
            S_IDLE: begin
                if (end_flag_c) begin
                    state_d  = S_DONE;
                    over_d   = 1'b1;
                    result_d = end_res_c;
                end else if (grant0_c || grant1_c) begin
                    // The pulse register doubles as the latched direction.
                    pulse_d = 4'(4'b0001 << (grant1_c ? bus.p1_dir : bus.p0_dir));
                    last_d  = grant1_c;
                    rr_d    = grant0_c;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // The pulse is already on the wire, so it counts even if the game ends now.
                if (move_count_q != {COUNT_W{1'b1}}) begin
                    move_count_d = move_count_q + COUNT_W'(1);
                end
                settle_d = SETTLE_W'(SETTLE_CYC);
                if (end_flag_c) begin
                    state_d  = S_DONE;
                    over_d   = 1'b1;
                    result_d = end_res_c;
                end else begin
                    state_d = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (end_flag_c) begin
                    state_d  = S_DONE;
                    over_d   = 1'b1;
                    result_d = end_res_c;
                end else if (settle_q == SETTLE_W'(1)) begin
                    if (move_count_q == COUNT_W'(MAX_MOVES)) begin
                        state_d  = S_DONE;
                        over_d   = 1'b1;
                        result_d = RES_TIMEOUT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.p0_ready    = grant0_c;
    assign bus.p1_ready    = grant1_c;
    assign bus.n           = pulse_q[0];
    assign bus.s           = pulse_q[1];
    assign bus.e           = pulse_q[2];
    assign bus.w           = pulse_q[3];
    assign bus.game_over   = over_q;
    assign bus.result      = result_q;
    assign bus.move_count  = move_count_q;
    assign bus.last_player = last_q;

endmodule
